// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit and receive paths.
//   rx_state_t         : receiver FSM state encoding
//   PAR_EVEN, PAR_ODD  : parity-type encoding on PAR_TYP (same on TX and RX)
//   DEFAULT_DATA_WIDTH : default number of data bits per frame
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_rx_data_sampling.sv
// uart_rx_data_sampling
// Captures RX_IN at the three edges around the centre of a bit period
// (PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1) and presents the majority.
// Ports:
//   CLK, RST     : oversampling clock, asynchronous active-low reset
//   RX_IN        : synchronised serial line
//   PRESCALE     : oversampling ratio latched for the current frame
//   edge_cnt     : position within the current bit (0..PRESCALE-1)
//   enable       : capture only while a frame is in progress
//   sampled_bit  : 2-of-3 majority; meaningful from edge PRESCALE/2+2 onwards
module uart_rx_data_sampling (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] PRESCALE,
  input  logic [5:0] edge_cnt,
  input  logic       enable,
  output logic       sampled_bit
);

  logic [5:0] half;
  logic [2:0] samples;

  assign half = PRESCALE >> 1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samples <= 3'b000;
    end else if (enable) begin
      if (edge_cnt == half - 6'd1) samples[0] <= RX_IN;
      if (edge_cnt == half)        samples[1] <= RX_IN;
      if (edge_cnt == half + 6'd1) samples[2] <= RX_IN;
    end
  end

  // Majority vote: a single-cycle glitch on one sample cannot flip the bit.
  assign sampled_bit = (samples[0] & samples[1]) |
                       (samples[0] & samples[2]) |
                       (samples[1] & samples[2]);

endmodule

// File: rtl/uart_rx_top.sv
// uart_rx_top
// UART receiver: start-bit detection with glitch rejection, LSB-first
// deserialisation, optional parity check and stop-bit check.
// Ports:
//   CLK, RST    : oversampling clock, asynchronous active-low reset
//   RX_IN       : serial line, idle high, already synchronised to CLK
//   PRESCALE    : oversampling ratio (8/16/32), latched at start-bit detection
//   PAR_EN      : parity bit present, latched at start-bit detection
//   PAR_TYP     : 0 even / 1 odd parity, latched at start-bit detection
//   P_DATA      : last good word, held until the next good frame
//   DATA_VALID  : one-cycle strobe when P_DATA updates
//   PAR_ERR     : one-cycle strobe, parity mismatch in the frame just ended
//   STP_ERR     : one-cycle strobe, stop bit sampled as 0
//   dbg_state   : current receiver FSM state (rx_state_t encoding)
// Output protocol: DATA_VALID is a valid-only strobe with no ready; the
// consumer must capture P_DATA in the cycle DATA_VALID is high. Error
// strobes share that cycle (c0 + frame length) and never coincide with it.
module uart_rx_top
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic [2:0]            dbg_state
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_t             state, next_state;
  logic [5:0]            edge_cnt;
  logic [5:0]            presc_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_bad_q;
  logic                  sampled_bit;
  logic                  last_edge;
  logic                  sample_ready;
  logic                  last_bit;

  assign last_edge    = (edge_cnt == presc_q - 6'd1);
  assign sample_ready = (edge_cnt == (presc_q >> 1) + 6'd2);
  assign last_bit     = (bit_cnt == BCW'(DATA_WIDTH - 1));
  assign dbg_state    = state;

  uart_rx_data_sampling u_sampling (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PRESCALE    (presc_q),
    .edge_cnt    (edge_cnt),
    .enable      (state != IDLE),
    .sampled_bit (sampled_bit)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!RX_IN) next_state = START;
      // A start bit that reads back as 1 at its centre was a glitch.
      START:   if (sample_ready && sampled_bit) next_state = IDLE;
               else if (last_edge)             next_state = DATA;
      DATA:    if (last_edge && last_bit) next_state = par_en_q ? PARITY : STOP;
      PARITY:  if (last_edge) next_state = STOP;
      STOP:    if (last_edge) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Counters, configuration latch, deserialiser and parity checker.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
    end else if (state == IDLE) begin
      bit_cnt <= '0;
      if (!RX_IN) begin
        // This cycle is edge 0 of the start bit, so the next one is edge 1.
        edge_cnt  <= 6'd1;
        presc_q   <= PRESCALE;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        par_bad_q <= 1'b0;
      end else begin
        edge_cnt <= '0;
      end
    end else begin
      if (next_state == IDLE || last_edge) edge_cnt <= '0;
      else                                 edge_cnt <= edge_cnt + 6'd1;

      if (state == DATA) begin
        if (sample_ready) shift_q[bit_cnt] <= sampled_bit;
        if (last_edge)    bit_cnt <= last_bit ? '0 : bit_cnt + BCW'(1);
      end

      if (state == PARITY && sample_ready)
        par_bad_q <= (sampled_bit != (^shift_q ^ par_typ_q));
    end
  end

  // Frame result, registered so it appears the cycle after the stop bit ends.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      if (state == STOP && last_edge) begin
        STP_ERR <= ~sampled_bit;
        PAR_ERR <= par_bad_q;
        if (sampled_bit && !par_bad_q) begin
          P_DATA     <= shift_q;
          DATA_VALID <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_top.sv
// tb_uart_rx_top
// Directed bench for uart_rx_top: frames are built bit by bit from
// hand-chosen words; pulse cycles are checked against c0 + frame length.
module tb_uart_rx_top;
  import uart_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] PRESCALE = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;
  logic [2:0] dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Scoreboard: expected words, popped on each DATA_VALID.
  logic [7:0] exp_q[$];
  int dv_n = 0, pe_n = 0, se_n = 0;
  int dv_cyc = -1, dv_prev_cyc = -1, pe_cyc = -1, se_cyc = -1;

  uart_rx_top dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR),
    .dbg_state  (dbg_state)
  );

  // Clock / cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (RST) begin
      if (DATA_VALID) begin
        dv_n++;
        dv_prev_cyc = dv_cyc;
        dv_cyc = cyc;
        if (exp_q.size() == 0) check("dv_unexpected", 32'd1, 32'd0);
        else                   check("dv_data", {24'd0, P_DATA}, {24'd0, exp_q.pop_front()});
      end
      if (PAR_ERR) begin pe_n++; pe_cyc = cyc; end
      if (STP_ERR) begin se_n++; se_cyc = cyc; end
    end
  end

  // Driver: hold one bit for p cycles; optional one-cycle flip at edge p/2.
  task automatic line(input logic b, input int p, input logic glitch);
    RX_IN = b;
    if (glitch) begin
      repeat (p / 2) @(posedge CLK);
      #1 RX_IN = ~b;
      @(posedge CLK);
      #1 RX_IN = b;
      repeat (p - p / 2 - 1) @(posedge CLK);
    end else begin
      repeat (p) @(posedge CLK);
    end
    #1;
  endtask

  // Driver: whole frame; called and returns 1 time unit after a posedge.
  task automatic send_frame(input logic [7:0] d, input int p, input logic pe,
                            input logic pt, input logic bad_par, input logic stop_v,
                            input int glitch_bit, output int c0);
    PRESCALE = 6'(p);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    c0 = cyc;
    line(1'b0, p, 1'b0);
    for (int i = 0; i < 8; i++) line(d[i], p, i == glitch_bit);
    if (pe) line((^d ^ pt) ^ bad_par, p, 1'b0);
    line(stop_v, p, 1'b0);
    RX_IN = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, dv0, pe0, se0;

    // Reset
    RST = 1'b0;
    idle_cycles(3);
    check("rst_p_data", {24'd0, P_DATA}, 32'h0);
    check("rst_dv", {31'd0, DATA_VALID}, 32'd0);
    check("rst_pe", {31'd0, PAR_ERR}, 32'd0);
    check("rst_se", {31'd0, STP_ERR}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    RST = 1'b1;
    idle_cycles(3);

    // 0xA5, P8, even parity
    dv0 = dv_n; pe0 = pe_n; se0 = se_n;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 8, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1, c0);
    idle_cycles(3);
    check("a5_dv_cnt", dv_n - dv0, 1);
    check("a5_dv_cyc", dv_cyc, c0 + 88);
    check("a5_no_err", (pe_n - pe0) + (se_n - se0), 0);
    check("a5_p_data", {24'd0, P_DATA}, 32'hA5);

    // 0x3C, odd parity, parity bit corrupted
    dv0 = dv_n; pe0 = pe_n; se0 = se_n;
    send_frame(8'h3C, 8, 1'b1, PAR_ODD, 1'b1, 1'b1, -1, c0);
    idle_cycles(3);
    check("3c_pe_cnt", pe_n - pe0, 1);
    check("3c_pe_cyc", pe_cyc, c0 + 88);
    check("3c_no_dv", dv_n - dv0, 0);
    check("3c_no_se", se_n - se0, 0);
    check("3c_p_data", {24'd0, P_DATA}, 32'hA5);

    // 0x81, no parity, stop bit 0, P16
    dv0 = dv_n; pe0 = pe_n; se0 = se_n;
    send_frame(8'h81, 16, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1, c0);
    idle_cycles(3);
    check("81_se_cnt", se_n - se0, 1);
    check("81_se_cyc", se_cyc, c0 + 160);
    check("81_no_dv", dv_n - dv0, 0);
    check("81_no_pe", pe_n - pe0, 0);
    check("81_p_data", {24'd0, P_DATA}, 32'hA5);

    // Short start pulse (P/2-2 = 2 cycles) is rejected
    dv0 = dv_n; pe0 = pe_n; se0 = se_n;
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    c0 = cyc;
    RX_IN = 1'b0;
    idle_cycles(2);
    RX_IN = 1'b1;
    idle_cycles(4);
    check("glitch_state_start", {29'd0, dbg_state}, 32'd1);
    idle_cycles(1);
    check("glitch_state_idle", {29'd0, dbg_state}, 32'd0);
    idle_cycles(4);
    check("glitch_no_out", (dv_n - dv0) + (pe_n - pe0) + (se_n - se0), 0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, c0);
    idle_cycles(3);
    check("55_dv_cyc", dv_cyc, c0 + 80);
    check("55_p_data", {24'd0, P_DATA}, 32'h55);

    // Back-to-back 0x00, 0xFF at P32, no gap
    dv0 = dv_n;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 32, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, c0);
    send_frame(8'hFF, 32, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, c1);
    idle_cycles(3);
    check("b2b_dv_cnt", dv_n - dv0, 2);
    check("b2b_first_cyc", dv_prev_cyc, c0 + 320);
    check("b2b_spacing", dv_cyc - dv_prev_cyc, 320);
    check("b2b_p_data", {24'd0, P_DATA}, 32'hFF);

    // One-cycle glitch at the centre sample of data bit 3
    dv0 = dv_n; pe0 = pe_n;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 16, 1'b1, PAR_EVEN, 1'b0, 1'b1, 3, c0);
    idle_cycles(3);
    check("mv_dv_cyc", dv_cyc, c0 + 176);
    check("mv_no_pe", pe_n - pe0, 0);
    check("mv_p_data", {24'd0, P_DATA}, 32'h5A);

    // Reset in the middle of DATA
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    line(1'b0, 8, 1'b0);
    line(1'b1, 8, 1'b0);
    line(1'b0, 8, 1'b0);
    RX_IN = 1'b1;
    idle_cycles(3);
    check("mid_state_data", {29'd0, dbg_state}, 32'd2);
    RST = 1'b0;
    #1;
    check("mid_rst_p_data", {24'd0, P_DATA}, 32'h0);
    check("mid_rst_state", {29'd0, dbg_state}, 32'd0);
    check("mid_rst_flags", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);
    idle_cycles(2);
    RST = 1'b1;
    idle_cycles(2);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 8, 1'b1, PAR_ODD, 1'b0, 1'b1, -1, c0);
    idle_cycles(3);
    check("96_dv_cyc", dv_cyc, c0 + 88);
    check("96_p_data", {24'd0, P_DATA}, 32'h96);
    check("exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
